// File: rtl/recv_lane_arbiter.sv
// Round-robin arbiter sharing one byte receiver between NUM_LANES lanes.
// Define RECV_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module recv_lane_arbiter #(
  parameter int          NUM_LANES      = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_LANES-1:0]         lane_req,
  input  logic [8*NUM_LANES-1:0]       lane_data,
  output logic [NUM_LANES-1:0]         lane_gnt,
  input  logic                         rx_rdy,
  output logic                         rx_start,
  output logic [7:0]                   rx_data,
  output logic [$clog2(NUM_LANES)-1:0] active_lane,
  output logic                         busy,
  output logic                         timeout
);

  localparam int LW = $clog2(NUM_LANES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_REL   = 2'd3;

  logic [1:0]    state;
  logic [15:0]   wd;
  logic [15:0]   wd_inc;
  logic          wd_hit;
  logic [LW-1:0] winner;

  assign wd_inc = wd + 16'd1;
  assign wd_hit = (TIMEOUT_CYCLES != 16'd0) &&
                  (wd_inc == TIMEOUT_CYCLES);

`ifdef RECV_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_req[i]) winner = LW'(i);
    end
  end
`else
  logic [LW-1:0] rr_ptr;
  logic [LW-1:0] cand;
  logic          hit;

  // Scan starts just after the last winner and wraps.
  always_comb begin
    winner = '0;
    cand   = '0;
    hit    = 1'b0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = LW'((int'(rr_ptr) + k) % NUM_LANES);
      if (!hit && lane_req[cand]) begin
        hit    = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= LW'(NUM_LANES - 1);
    end else if (state == S_REL) begin
      rr_ptr <= active_lane;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lane_gnt    <= '0;
      active_lane <= '0;
      wd          <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|lane_req && rx_rdy) begin
            lane_gnt    <= {{(NUM_LANES-1){1'b0}}, 1'b1} << winner;
            active_lane <= winner;
            state       <= S_START;
          end
        end
        S_START: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (wd != 16'hFFFF) wd <= wd_inc;
          // Receiver idle ends the frame; rdy never accepted is the same exit.
          if (rx_rdy) begin
            lane_gnt <= '0;
            state    <= S_REL;
          end else if (wd_hit) begin
            lane_gnt <= '0;
            timeout  <= 1'b1;
            state    <= S_REL;
          end
        end
        S_REL: begin
          wd    <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rx_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_gnt[i]) rx_data = rx_data | lane_data[8*i +: 8];
    end
  end

  assign rx_start = (state == S_START);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_recv_lane_arbiter.sv
// Self-checking bench for recv_lane_arbiter: vector table plus
// scoreboarded frame, fairness, watchdog and reset sequences.
module tb_recv_lane_arbiter;

  localparam int N = 4;
`ifdef RECV_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] lane_req;
  logic [8*N-1:0] lane_data;
  logic [N-1:0] lane_gnt;
  logic         rx_rdy;
  logic         rx_start;
  logic [7:0]   rx_data;
  logic [1:0]   active_lane;
  logic         busy;
  logic         timeout;

  always #5 clk = ~clk;

  recv_lane_arbiter #(
    .NUM_LANES(N),
    .TIMEOUT_CYCLES(16'd16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lane_req(lane_req),
    .lane_data(lane_data),
    .lane_gnt(lane_gnt),
    .rx_rdy(rx_rdy),
    .rx_start(rx_start),
    .rx_data(rx_data),
    .active_lane(active_lane),
    .busy(busy),
    .timeout(timeout)
  );

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic       start;
    logic [7:0] data;
    logic [1:0] act;
    logic       bsy;
    logic       to;
  } vec_t;

  vec_t tbl[10];

  int total  = 0;
  int passed = 0;

  int lane_pos[N];
  bit rcv_busy;
  int rcv_cnt;
  int rcv_len;
  int cur_lane;
  bit rcv_en;
  bit byte_chk;
  int steps;
  int starts;
  int start_step;
  int to_step;
  int run_cnt;
  int lane_q[$];

  logic       s_start;
  logic       s_busy;
  logic       s_to;
  logic [7:0] s_data;
  logic [3:0] s_gnt;
  logic [1:0] s_active;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] lane_byte(input int lane, input int k);
    if (k < 7) return 8'hAA;
    if (k == 7) return 8'hAB;
    return 8'((lane << 5) + k);
  endfunction

  task automatic drive_lanes();
    for (int i = 0; i < N; i++) lane_data[8*i +: 8] = lane_byte(i, lane_pos[i]);
  endtask

  task automatic clear_models();
    for (int i = 0; i < N; i++) lane_pos[i] = 0;
    rcv_busy = 1'b0;
    rcv_cnt  = 0;
    rcv_len  = 2;
    rcv_en   = 1'b1;
    byte_chk = 1'b0;
    starts   = 0;
    steps    = 0;
    lane_q.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    lane_req  = '0;
    rx_rdy    = 1'b1;
    lane_data = '0;
    clear_models();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One cycle: drive from models, sample, clock, update lane and receiver models.
  task automatic step();
    int e;
    drive_lanes();
    rx_rdy = !rcv_busy;
    #1;
    s_start  = rx_start;
    s_busy   = busy;
    s_to     = timeout;
    s_data   = rx_data;
    s_gnt    = lane_gnt;
    s_active = active_lane;
    if (s_start) start_step = steps;
    if (s_to) to_step = steps;
    @(posedge clk);
    #1;
    steps++;
    for (int i = 0; i < N; i++) if (s_gnt[i]) lane_pos[i]++;
    if (s_start) begin
      starts++;
      if (lane_q.size() == 0) begin
        chk("grant_expected", 32'(lane_q.size()), 1);
      end else begin
        e = lane_q.pop_front();
        chk("grant_lane", 32'(s_active), 32'(e));
        chk("grant_onehot", 32'(s_gnt), 32'(1) << e);
        if (rcv_en && !rcv_busy) begin
          rcv_busy = 1'b1;
          rcv_cnt  = 0;
          cur_lane = e;
        end
      end
    end
    if (rcv_busy) begin
      if (byte_chk) chk("rx_byte", 32'(s_data), 32'(lane_byte(cur_lane, rcv_cnt)));
      rcv_cnt++;
      if (rcv_cnt >= rcv_len) rcv_busy = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] w5;
    logic [3:0] g5;
    bit done;

    do_reset();
    chk("rst_gnt", 32'(lane_gnt), 0);
    chk("rst_start", 32'(rx_start), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_active", 32'(active_lane), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout), 0);

    w5 = FIXED ? 2'd0 : 2'd3;
    g5 = 4'(1 << w5);
    tbl[0] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1, 1'b0};
    tbl[1] = '{4'b0000, 1'b0, 4'b0100, 1'b0, 8'hA2, 2'd2, 1'b1, 1'b0};
    tbl[2] = '{4'b0000, 1'b0, 4'b0100, 1'b0, 8'hA2, 2'd2, 1'b1, 1'b0};
    tbl[3] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0};
    tbl[4] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0};
    tbl[5] = '{4'b1111, 1'b1, g5, 1'b1, 8'hA0 + 8'(w5), w5, 1'b1, 1'b0};
    tbl[6] = '{4'b1111, 1'b1, g5, 1'b0, 8'hA0 + 8'(w5), w5, 1'b1, 1'b0};
    tbl[7] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, w5, 1'b1, 1'b0};
    tbl[8] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, w5, 1'b0, 1'b0};
    tbl[9] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1, 1'b0};

    lane_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int r = 0; r < 10; r++) begin
      lane_req = tbl[r].req;
      rx_rdy   = tbl[r].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_gnt", r), 32'(lane_gnt), 32'(tbl[r].gnt));
      chk($sformatf("t%0d_start", r), 32'(rx_start), 32'(tbl[r].start));
      chk($sformatf("t%0d_data", r), 32'(rx_data), 32'(tbl[r].data));
      chk($sformatf("t%0d_active", r), 32'(active_lane), 32'(tbl[r].act));
      chk($sformatf("t%0d_busy", r), 32'(busy), 32'(tbl[r].bsy));
      chk($sformatf("t%0d_timeout", r), 32'(timeout), 32'(tbl[r].to));
    end

    // Full frame through a modelled receiver on lane 1.
    do_reset();
    rcv_len  = 12;
    byte_chk = 1'b1;
    lane_req = 4'b0010;
    lane_q.push_back(1);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      if (starts > 0) lane_req = '0;
      if (starts > 0 && !rcv_busy) done = 1'b1;
    end
    chk("frame_done", 32'(done), 1);
    chk("frame_bytes", 32'(rcv_cnt), 12);
    byte_chk = 1'b0;
    step();
    chk("frame_run_hold", 32'(s_gnt), 4'b0010);
    step();
    chk("rel_gnt", 32'(s_gnt), 0);
    chk("rel_busy", 32'(s_busy), 1);
    chk("rel_data", 32'(s_data), 0);
    step();
    chk("idle_busy", 32'(s_busy), 0);
    chk("frame_q_empty", 32'(lane_q.size()), 0);

    // Fairness with all lanes requesting.
    do_reset();
    lane_req = 4'b1111;
    for (int k = 0; k < 8; k++) lane_q.push_back(FIXED ? 0 : k % 4);
    for (int c = 0; c < 200 && starts < 8; c++) step();
    lane_req = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (!s_busy) break;
    end
    chk("fair_starts", 32'(starts), 8);
    chk("fair_q_empty", 32'(lane_q.size()), 0);
    chk("fair_idle", 32'(s_busy), 0);

    // Watchdog: receiver accepts the start and never finishes.
    do_reset();
    rcv_len    = 1 << 30;
    lane_req   = 4'b0100;
    lane_q.push_back(2);
    start_step = -1;
    to_step    = -1;
    run_cnt    = 0;
    for (int c = 0; c < 40 && to_step < 0; c++) begin
      step();
      if (s_busy && s_gnt != 0 && !s_start) run_cnt++;
    end
    chk("wd_fired", 32'(to_step >= 0), 1);
    chk("wd_delay", 32'(to_step - start_step), 17);
    chk("wd_run_cycles", 32'(run_cnt), 16);
    chk("wd_rel_gnt", 32'(s_gnt), 0);
    step();
    chk("wd_pulse_len", 32'(s_to), 0);
    lane_req = 4'b0101;
    for (int c = 0; c < 10; c++) step();
    chk("wd_hold_idle", 32'(s_busy), 0);
    chk("wd_no_grant", 32'(starts), 1);
    rcv_busy = 1'b0;
    rcv_len  = 2;
    lane_q.push_back(0);
    for (int c = 0; c < 10 && starts < 2; c++) step();
    chk("wd_regrant", 32'(starts), 2);
    chk("wd_q_empty", 32'(lane_q.size()), 0);

    // Asynchronous reset in the middle of a lane 1 frame.
    do_reset();
    rcv_len  = 1 << 30;
    lane_req = 4'b0010;
    lane_q.push_back(1);
    for (int c = 0; c < 10 && starts < 1; c++) step();
    step();
    chk("pre_rst_gnt", 32'(s_gnt), 4'b0010);
    chk("pre_rst_data", 32'(s_data), 32'(lane_byte(1, lane_pos[1] - 1)));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(lane_gnt), 0);
    chk("mid_rst_start", 32'(rx_start), 0);
    chk("mid_rst_data", 32'(rx_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_models();
    lane_req = 4'b1111;
    lane_q.push_back(0);
    for (int c = 0; c < 10 && starts < 1; c++) step();
    chk("post_rst_first", 32'(starts), 1);
    chk("post_rst_q_empty", 32'(lane_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
